// File: rtl/wb_arbiter.sv
// Write-back arbiter: round-robin ALU/load grant into a registered RF write port, plus a pending-write scoreboard.
// Optional WB_ARB_FWD_EN exposes the accepted transfer combinationally for operand bypass.
module wb_arbiter #(
    parameter int XLEN = 64,
    parameter int AW   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [AW-1:0]     alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [AW-1:0]     mem_rd,
    input  logic [XLEN-1:0]   mem_data,
    input  logic              issue_valid,
    input  logic [AW-1:0]     issue_rd,
    output logic              rf_wen,
    output logic [AW-1:0]     rf_rd,
    output logic [XLEN-1:0]   rf_wd,
`ifdef WB_ARB_FWD_EN
    output logic              fwd_valid,
    output logic [AW-1:0]     fwd_rd,
    output logic [XLEN-1:0]   fwd_data,
`endif
    output logic [2**AW-1:0]  sb_busy
);
    localparam int NREG = 2**AW;

    // ptr_q = 0 favours the ALU on contention, 1 favours the load unit
    logic              ptr_q, ptr_d;
    logic              wen_q, wen_d;
    logic [AW-1:0]     rd_q, rd_d;
    logic [XLEN-1:0]   data_q, data_d;
    logic [NREG-1:0]   busy_q, busy_d;
    logic [NREG-1:0]   set_vec, clr_vec;
    logic              gnt_alu, gnt_mem, acc;
    logic [AW-1:0]     sel_rd;
    logic [XLEN-1:0]   sel_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q  <= 1'b0;
            wen_q  <= 1'b0;
            rd_q   <= '0;
            data_q <= '0;
            busy_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            wen_q  <= wen_d;
            rd_q   <= rd_d;
            data_q <= data_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        gnt_alu  = !rst && alu_valid && (!mem_valid || !ptr_q);
        gnt_mem  = !rst && mem_valid && (!alu_valid ||  ptr_q);
        acc      = gnt_alu || gnt_mem;
        sel_rd   = gnt_mem ? mem_rd   : alu_rd;
        sel_data = gnt_mem ? mem_data : alu_data;

        ptr_d    = acc ? gnt_alu : ptr_q;
        // x0 requests burn a grant slot but never reach the register file
        wen_d    = acc && (sel_rd != '0);
        rd_d     = wen_d ? sel_rd   : rd_q;
        data_d   = wen_d ? sel_data : data_q;

        set_vec  = '0;
        clr_vec  = '0;
        if (issue_valid) set_vec[issue_rd] = 1'b1;
        if (wen_d)       clr_vec[sel_rd]   = 1'b1;
        // set applied after clear so a same-cycle issue keeps the bit busy
        busy_d    = (busy_q & ~clr_vec) | set_vec;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        alu_ready = gnt_alu;
        mem_ready = gnt_mem;
        // a write whose stage lines up with reset is dropped
        rf_wen    = wen_q && !rst;
        rf_rd     = rd_q;
        rf_wd     = data_q;
        sb_busy   = busy_q;
`ifdef WB_ARB_FWD_EN
        fwd_valid = wen_d;
        fwd_rd    = sel_rd;
        fwd_data  = sel_data;
`endif
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Write-back controller for the 32x64-bit single-write-port register file.
- Arbitrates between two write-back requesters, the ALU and the load unit, with round-robin fairness and a valid/ready handshake.
- Drives the register file's write enable, address and data from a registered output stage.
- Keeps a pending-write scoreboard that the issue stage uses for RAW hazard stalls.

Parameters:
- XLEN, 64, data width of register file write data.
- AW, 5, register address width; the file has 2**AW registers.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- alu_valid  input  1  ALU write-back request.
- alu_ready  output  1  ALU request accepted this cycle.
- alu_rd  input  AW  ALU destination register.
- alu_data  input  XLEN  ALU result.
- mem_valid  input  1  load-unit write-back request.
- mem_ready  output  1  load request accepted this cycle.
- mem_rd  input  AW  load destination register.
- mem_data  input  XLEN  load result.
- issue_valid  input  1  instruction with a destination issued this cycle.
- issue_rd  input  AW  destination of the issued instruction.
- rf_wen  output  1  register file write enable.
- rf_rd  output  AW  register file write address.
- rf_wd  output  XLEN  register file write data.
- sb_busy  output  2**AW  pending-write bit per register; bit 0 is always 0.
- fwd_valid, fwd_rd (AW), fwd_data (XLEN)  output  bypass of the current grant; present only with WB_ARB_FWD_EN.

Behaviour:
- Reset (rst=1 at posedge):
  - rf_wen=0, rf_rd=0, rf_wd=0, sb_busy=0.
  - Priority pointer is set to ALU.
  - alu_ready and mem_ready are combinational and are 0 while rst=1.
- Handshake:
  - A transfer occurs when valid && ready in the same cycle.
  - Requesters hold valid, rd and data stable until accepted. valid must not depend on ready.
  - At most one ready is high per cycle.
- Grant:
  - Only one requester valid: that requester gets ready=1.
  - Both valid: the pointer side gets ready.
  - After any grant, the pointer moves to the non-granted side.
  - Neither valid: no grant, pointer unchanged.
- Write stage:
  - Accepted request at cycle N gives rf_wen=1, rf_rd=rd, rf_wd=data at cycle N+1. Latency is exactly 1 cycle.
  - rf_wen=0 in cycles that follow no acceptance. rf_rd and rf_wd hold their last values.
- rd==0:
  - The request is still accepted (ready=1) and consumes its grant slot.
  - rf_wen stays 0 next cycle and the scoreboard is untouched.
- Scoreboard:
  - issue_valid with issue_rd!=0 sets sb_busy[issue_rd] at the next edge.
  - An accepted write-back to rd!=0 clears sb_busy[rd] at the next edge, the same edge on which rf_wen rises.
  - Set and clear of the same rd in the same cycle: set wins, bit stays 1.
  - Setting an already-busy bit leaves it 1; there is no counting.
  - Clearing a non-busy bit leaves it 0.
  - Set and clear of different registers in the same cycle both take effect.
- Throughput:
  - One write per cycle sustained.
  - Under continuous dual contention, grants alternate ALU, MEM, ALU, …
- Reset mid-operation:
  - An in-flight accepted request whose write stage coincides with rst is dropped (rf_wen=0).
  - Scoreboard and pointer are cleared regardless of pending activity.

Optional Feature:
- WB_ARB_FWD_EN defined:
  - fwd_valid, fwd_rd and fwd_data ports exist.
  - They combinationally present the transfer accepted this cycle: fwd_valid = (alu_valid&&alu_ready || mem_valid&&mem_ready) && rd!=0.
  - This gives operand bypass one cycle before rf_wen. fwd_valid is 0 during rst.
- Not defined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then alu_valid=1, alu_rd=5, alu_data=20 for one cycle -> alu_ready=1 that cycle; next cycle rf_wen=1, rf_rd=5, rf_wd=20.
- Both valid continuously for 4 cycles (alu_rd=2, mem_rd=3) -> grant order ALU, MEM, ALU, MEM; rf_rd sequence 2, 3, 2, 3; never both ready high.
- issue_valid with issue_rd=8 -> sb_busy[8]=1 next cycle; mem write-back rd=8, data 0xFF accepted -> sb_busy[8]=0 on the same edge rf_wen=1, rf_wd=0xFF.
- Same cycle: issue_rd=14 plus ALU write-back rd=14 accepted -> rf_wen=1 for x14 next cycle and sb_busy[14] remains 1.
- alu_rd=0, alu_data=0xAA accepted -> rf_wen=0 next cycle, sb_busy unchanged, pointer moves to MEM.
- rst asserted the cycle after an acceptance -> rf_wen=0, sb_busy=0, and the first contended grant after reset goes to ALU; with WB_ARB_FWD_EN, fwd_valid=1, fwd_rd=5 in the acceptance cycle of test 1.
